// File: rtl/cache_arbiter.sv
// Two-client, single-port line arbiter between the L1 caches and physical memory.
// Round-robin grant; the winning request is captured so the memory port is stable until pmem_resp.
module cache_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] inst_pmem_address,
  input  logic              inst_pmem_read,
  output logic              inst_pmem_resp,
  output logic [LINE_W-1:0] inst_pmem_rdata,
  input  logic [ADDR_W-1:0] ev_address,
  input  logic              ev_read,
  input  logic              ev_write,
  input  logic [LINE_W-1:0] ev_wdata,
  output logic              data_pmem_resp,
  output logic [LINE_W-1:0] data_pmem_rdata,
  output logic [ADDR_W-1:0] pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic [CNT_W-1:0]  inst_grants,
  output logic [CNT_W-1:0]  data_grants,
  output logic [CNT_W-1:0]  conflict_cycles
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state;
  logic   last_d;
  logic   req_i;
  logic   req_d;
  logic   grant_i;
  logic   grant_d;

  // last_d = 0 means I won most recently, so D takes the next tie.
  always_comb begin
    req_i   = inst_pmem_read;
    req_d   = ev_read | ev_write;
    grant_d = req_d & (~req_i | ~last_d);
    grant_i = req_i & ~grant_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      last_d          <= 1'b0;
      pmem_address    <= '0;
      pmem_wdata      <= '0;
      pmem_read       <= 1'b0;
      pmem_write      <= 1'b0;
      inst_grants     <= '0;
      data_grants     <= '0;
      conflict_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i && req_d)
            conflict_cycles <= conflict_cycles + 1'b1;
          if (grant_d) begin
            state        <= SERVE_D;
            last_d       <= 1'b1;
            pmem_address <= ev_address;
            pmem_wdata   <= ev_wdata;
            // A simultaneous read+write is resolved as a write.
            pmem_write   <= ev_write;
            pmem_read    <= ~ev_write;
            data_grants  <= data_grants + 1'b1;
          end else if (grant_i) begin
            state        <= SERVE_I;
            last_d       <= 1'b0;
            pmem_address <= inst_pmem_address;
            pmem_wdata   <= '0;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            inst_grants  <= inst_grants + 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // Completion is forwarded combinationally in the pmem_resp cycle only.
  always_comb begin
    inst_pmem_resp  = 1'b0;
    data_pmem_resp  = 1'b0;
    inst_pmem_rdata = '0;
    data_pmem_rdata = '0;
    if (pmem_resp && state == SERVE_I) begin
      inst_pmem_resp  = 1'b1;
      inst_pmem_rdata = pmem_rdata;
    end
    if (pmem_resp && state == SERVE_D) begin
      data_pmem_resp  = 1'b1;
      data_pmem_rdata = pmem_rdata;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: transaction-level arbitration model feeds an expected queue,
// a negedge monitor pops and compares as the memory port and client responses appear.
module tb_cache_arbiter;

  logic         clk;
  logic         rst;
  logic [31:0]  inst_pmem_address;
  logic         inst_pmem_read;
  logic         inst_pmem_resp;
  logic [255:0] inst_pmem_rdata;
  logic [31:0]  ev_address;
  logic         ev_read;
  logic         ev_write;
  logic [255:0] ev_wdata;
  logic         data_pmem_resp;
  logic [255:0] data_pmem_rdata;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic [31:0]  inst_grants;
  logic [31:0]  data_grants;
  logic [31:0]  conflict_cycles;

  logic mem_resp;
  logic stray_resp;
  assign pmem_resp = mem_resp | stray_resp;

  cache_arbiter #(.ADDR_W(32), .LINE_W(256), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_pmem_address(inst_pmem_address), .inst_pmem_read(inst_pmem_read),
    .inst_pmem_resp(inst_pmem_resp), .inst_pmem_rdata(inst_pmem_rdata),
    .ev_address(ev_address), .ev_read(ev_read), .ev_write(ev_write), .ev_wdata(ev_wdata),
    .data_pmem_resp(data_pmem_resp), .data_pmem_rdata(data_pmem_rdata),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .inst_grants(inst_grants), .data_grants(data_grants), .conflict_cycles(conflict_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_A5A5}};
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom();
    a[4:0] = '0;
    return a;
  endfunction

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    bit           is_d;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    int           cyc;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] m_inst, m_data, m_conf;
  bit          m_busy, m_last_d;

  always @(posedge clk or posedge rst) begin
    bit   ri, rd, win_d;
    txn_t t;
    if (rst) begin
      m_busy = 0; m_last_d = 0;
      m_inst = '0; m_data = '0; m_conf = '0;
      exp_q.delete();
    end else if (m_busy) begin
      if (pmem_resp) m_busy = 0;
    end else begin
      ri = inst_pmem_read;
      rd = ev_read | ev_write;
      if (ri && rd) m_conf = m_conf + 1;
      if (ri || rd) begin
        win_d = rd && (!ri || !m_last_d);
        t.is_d = win_d;
        t.cyc  = cyc;
        if (win_d) begin
          t.wr = ev_write; t.addr = ev_address; t.wdata = ev_wdata;
          m_data = m_data + 1;
        end else begin
          t.wr = 0; t.addr = inst_pmem_address; t.wdata = '0;
          m_inst = m_inst + 1;
        end
        m_last_d = win_d;
        m_busy = 1;
        exp_q.push_back(t);
      end
    end
  end

  // ---------------- memory responder ----------------
  int mem_wait;
  initial begin
    mem_resp = 0;
    mem_wait = -1;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_resp = 0;
      pmem_rdata = rand_line();
      if (rst) mem_wait = -1;
      else if (mem_wait > 0) mem_wait--;
      else if (mem_wait == 0) begin
        mem_resp = 1;
        pmem_rdata = line_of(pmem_address);
        mem_wait = -1;
      end else if (pmem_read | pmem_write) mem_wait = $urandom_range(0, 3);
    end
  end

  // ---------------- monitor ----------------
  txn_t cur;
  bit   cur_valid = 0;
  bit   prev_strobe = 0;

  always @(negedge clk) begin
    bit strobe;
    cyc++;
    assert (!(ev_read && ev_write)) else $error("bench drove ev_read and ev_write together");
    if (rst) begin
      cur_valid = 0;
      prev_strobe = 0;
    end else begin
      strobe = pmem_read | pmem_write;
      chk("inst_grants", inst_grants, m_inst);
      chk("data_grants", data_grants, m_data);
      chk("conflict_cycles", conflict_cycles, m_conf);
      if (strobe && !prev_strobe) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_txn", 1'b1, 1'b0);
        end else begin
          cur = exp_q.pop_front();
          cur_valid = 1;
          chk("grant_latency", cyc, cur.cyc + 1);
          chk("pmem_address", pmem_address, cur.addr);
          chk("pmem_write", pmem_write, cur.wr);
          chk("pmem_read", pmem_read, !cur.wr);
          if (cur.wr) chk("pmem_wdata", pmem_wdata, cur.wdata);
        end
      end else if (strobe && cur_valid) begin
        chk("addr_stable", pmem_address, cur.addr);
      end
      if (!strobe) chk("resp_in_idle", {inst_pmem_resp, data_pmem_resp}, 2'b00);
      if (strobe && !pmem_resp) chk("resp_early", {inst_pmem_resp, data_pmem_resp}, 2'b00);
      if (strobe && pmem_resp && cur_valid) begin
        chk("inst_resp", inst_pmem_resp, !cur.is_d);
        chk("data_resp", data_pmem_resp, cur.is_d);
        if (cur.is_d) begin
          chk("data_rdata", data_pmem_rdata, line_of(cur.addr));
          chk("inst_rdata_idle", inst_pmem_rdata, 256'd0);
        end else begin
          chk("inst_rdata", inst_pmem_rdata, line_of(cur.addr));
          chk("data_rdata_idle", data_pmem_rdata, 256'd0);
        end
        cur_valid = 0;
      end
      prev_strobe = strobe;
    end
  end

  // ---------------- client drivers ----------------
  task automatic i_txn(input logic [31:0] a);
    bit done = 0;
    @(posedge clk); #1;
    inst_pmem_address = a;
    inst_pmem_read = 1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (inst_pmem_resp) done = 1;
    end
    if (!done) chk("inst_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    inst_pmem_read = 0;
    inst_pmem_address = rand_addr();
  endtask

  task automatic d_txn(input logic [31:0] a, input bit wr, input logic [255:0] wd,
                       input bit wiggle, input logic [31:0] a2);
    bit done = 0;
    @(posedge clk); #1;
    ev_address = a;
    ev_wdata = wd;
    ev_write = wr;
    ev_read = !wr;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (data_pmem_resp) done = 1;
      else if (wiggle && k == 1) begin
        ev_address = a2;
        ev_wdata = rand_line();
      end
    end
    if (!done) chk("data_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    ev_read = 0;
    ev_write = 0;
    ev_address = rand_addr();
  endtask

  task automatic reset_dut();
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1; stray_resp = 0;
    inst_pmem_address = '0; inst_pmem_read = 0;
    ev_address = '0; ev_read = 0; ev_write = 0; ev_wdata = '0;

    repeat (2) @(posedge clk); #1;
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_pmem_address", pmem_address, 32'd0);
    chk("rst_pmem_wdata", pmem_wdata, 256'd0);
    chk("rst_resps", {inst_pmem_resp, data_pmem_resp}, 2'b00);
    chk("rst_inst_rdata", inst_pmem_rdata, 256'd0);
    chk("rst_data_rdata", data_pmem_rdata, 256'd0);
    chk("rst_counters", {inst_grants, data_grants, conflict_cycles}, 96'd0);
    @(posedge clk); #1; rst = 0;

    // I-only read
    i_txn(32'h0000_0040);
    @(negedge clk);
    chk("t1_inst_grants", inst_grants, 32'd1);

    // tie from reset: D first, then I
    reset_dut();
    fork
      i_txn(32'h0000_1000);
      d_txn(32'h0000_2000, 0, '0, 0, '0);
    join
    @(negedge clk);
    chk("t2_counts", {inst_grants, data_grants, conflict_cycles}, {32'd1, 32'd1, 32'd1});

    // round-robin under continuous demand
    reset_dut();
    fork
      begin i_txn(32'h0000_3000); i_txn(32'h0000_3020); end
      begin d_txn(32'h0000_4000, 0, '0, 0, '0); d_txn(32'h0000_4020, 1, rand_line(), 0, '0); end
    join
    @(negedge clk);
    chk("t3_counts", {inst_grants, data_grants}, {32'd2, 32'd2});

    // fill then writeback, with address change mid-transfer
    reset_dut();
    d_txn(32'h0000_0100, 0, '0, 1, 32'h0000_0300);
    d_txn(32'h0000_0200, 1, {8{32'hDEAD_BEEF}}, 0, '0);
    @(negedge clk);
    chk("t4_data_grants", data_grants, 32'd2);

    // reset during SERVE_I, then a stray pmem_resp in IDLE
    reset_dut();
    @(posedge clk); #1;
    inst_pmem_address = 32'h0000_0040;
    inst_pmem_read = 1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (pmem_read) seen = 1;
    end
    chk("t6_strobe_seen", seen, 1'b1);
    @(posedge clk); #2;
    rst = 1;
    inst_pmem_read = 0;
    #1;
    chk("t6_strobes_low", {pmem_read, pmem_write}, 2'b00);
    chk("t6_resp_low", inst_pmem_resp, 1'b0);
    chk("t6_counters", {inst_grants, data_grants, conflict_cycles}, 96'd0);
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1; stray_resp = 1;
    @(negedge clk);
    chk("t6_stray_resp", {inst_pmem_resp, data_pmem_resp}, 2'b00);
    @(posedge clk); #1; stray_resp = 0;
    @(negedge clk);
    chk("t6_stray_idle", {pmem_read, pmem_write}, 2'b00);
    chk("t6_stray_counters", {inst_grants, data_grants}, 64'd0);
    i_txn(32'h0000_0080);
    @(negedge clk);
    chk("t6_recover", inst_grants, 32'd1);

    // randomized concurrent traffic
    reset_dut();
    fork
      for (int n = 0; n < 40; n++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        i_txn(rand_addr());
      end
      for (int n = 0; n < 40; n++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        d_txn(rand_addr(), $urandom_range(0, 1) == 1, rand_line(),
              $urandom_range(0, 1) == 1, rand_addr());
      end
    join
    @(negedge clk);
    chk("rand_total", inst_grants + data_grants, 32'd80);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
